pio_cmd_master: RTL and testbench

Host-side command initiator for the `pio` block. It parses a byte stream of 6-byte command packets, typically from a UART receiver, and drives the PIO control port (`action`, `mindex`, `index`, `din`) with single-cycle action strobes. PUSH and PULL are flow-controlled against the PIO FIFO flags. For PULL, it captures the PIO `dout` word and returns it as 4 bytes on an output byte stream. It sits between the host transport and `pio`.

---
 rtl/pio_cmd_pkg.sv | 41 ++++
 rtl/pio_cmd_master.sv | 205 ++++++++++++++++++++
 tb/tb_pio_cmd_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg: shared definitions for the PIO command master.
//   - PIO action codes (4-bit, passed straight through to the PIO control port)
//   - command packet length and header field positions
//   - FSM state encoding
package pio_cmd_pkg;

    // PIO action encoding
    localparam logic [3:0] ActNone  = 4'd0;
    localparam logic [3:0] ActInstr = 4'd1;
    localparam logic [3:0] ActPend  = 4'd2;
    localparam logic [3:0] ActPull  = 4'd3;
    localparam logic [3:0] ActPush  = 4'd4;
    localparam logic [3:0] ActGrps  = 4'd5;
    localparam logic [3:0] ActEn    = 4'd6;
    localparam logic [3:0] ActDiv   = 4'd7;
    localparam logic [3:0] ActSides = 4'd8;
    localparam logic [3:0] ActImm   = 4'd9;
    localparam logic [3:0] ActShift = 4'd10;
    localparam logic [3:0] ActIsrt  = 4'd11;
    localparam logic [3:0] ActPins  = 4'd12;
    localparam logic [3:0] ActJmpP  = 4'd13;
    localparam logic [3:0] ActPinDr = 4'd14;
    localparam logic [3:0] ActOsrt  = 4'd15;

    // Packet: hdr, idx, d0, d1, d2, d3
    localparam int unsigned PktLen     = 6;
    localparam int unsigned HdrActLsb  = 0;
    localparam int unsigned HdrActW    = 4;
    localparam int unsigned HdrMidxLsb = 4;
    localparam int unsigned HdrMidxW   = 2;
    localparam int unsigned IdxW       = 5;

    typedef enum logic [2:0] {
        StRecv,
        StWait,
        StIssue,
        StCapture,
        StSend
    } state_e;

endpackage

// File: rtl/pio_cmd_master.sv
// pio_cmd_master: parses 6-byte command packets from a byte stream and drives the PIO
// control port with one-cycle action strobes. PUSH/PULL wait on the per-machine FIFO
// flags; PULL returns the captured dout word as 4 bytes, LSB first.
//
// Ports:
//   clk_i, reset_ni           clock, asynchronous active-low reset
//   in_valid_i/in_data_i/in_ready_o     command byte stream (in)
//   out_valid_o/out_data_o/out_ready_i  response byte stream (out)
//   action_o, mindex_o, index_o, din_o  PIO control port (action is a strobe)
//   dout_i                    PIO read data, valid the cycle after a PULL strobe
//   full_i, empty_i           PIO TX-full / RX-empty flags per machine
//   busy_o                    FSM is not receiving
//   err_o                     one-cycle pulse when a command times out in WAIT
module pio_cmd_master
    import pio_cmd_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    input  logic        out_ready_i,
    output logic [3:0]  action_o,
    output logic [1:0]  mindex_o,
    output logic [4:0]  index_o,
    output logic [31:0] din_o,
    input  logic [31:0] dout_i,
    input  logic [3:0]  full_i,
    input  logic [3:0]  empty_i,
    output logic        busy_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  cmd_act_q, cmd_act_d;
    logic [1:0]  cmd_midx_q, cmd_midx_d;
    logic [4:0]  cmd_idx_q, cmd_idx_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]  action_q, action_d;
    logic [1:0]  mindex_q, mindex_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] din_q, din_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  send_cnt_q, send_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        err_q, err_d;

    logic wait_ok;
    logic wait_expired;

    // Flow-control condition for the pending command
    always_comb begin
        wait_ok = 1'b1;
        if (cmd_act_q == ActPush) begin
            wait_ok = ~full_i[cmd_midx_q];
        end else if (cmd_act_q == ActPull) begin
            wait_ok = ~empty_i[cmd_midx_q];
        end
    end

    // Counter holds the number of WAIT cycles already spent, so the command is dropped at
    // the end of the WAIT_LIMIT-th cycle.
    assign wait_expired = (WAIT_LIMIT != 0) && ({16'd0, wait_cnt_q} == (WAIT_LIMIT - 1));

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        cmd_act_d  = cmd_act_q;
        cmd_midx_d = cmd_midx_q;
        cmd_idx_d  = cmd_idx_q;
        cmd_data_d = cmd_data_q;
        wait_cnt_d = wait_cnt_q;
        action_d   = ActNone;
        mindex_d   = mindex_q;
        index_d    = index_q;
        din_d      = din_q;
        shift_d    = shift_q;
        send_cnt_d = send_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;

        unique case (state_q)
            StRecv: begin
                wait_cnt_d = '0;
                if (in_valid_i) begin
                    case (byte_cnt_q)
                        3'd0: begin
                            cmd_act_d  = in_data_i[HdrActLsb +: HdrActW];
                            cmd_midx_d = in_data_i[HdrMidxLsb +: HdrMidxW];
                        end
                        3'd1:    cmd_idx_d          = in_data_i[IdxW-1:0];
                        3'd2:    cmd_data_d[7:0]    = in_data_i;
                        3'd3:    cmd_data_d[15:8]   = in_data_i;
                        3'd4:    cmd_data_d[23:16]  = in_data_i;
                        default: cmd_data_d[31:24]  = in_data_i;
                    endcase
                    if (byte_cnt_q == 3'(PktLen - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = StWait;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            StWait: begin
                if (cmd_act_q == ActNone) begin
                    state_d = StRecv;
                end else if (wait_ok) begin
                    state_d  = StIssue;
                    action_d = cmd_act_q;
                    mindex_d = cmd_midx_q;
                    index_d  = cmd_idx_q;
                    din_d    = cmd_data_q;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = StRecv;
                end else begin
                    wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 16'd1;
                end
            end
            StIssue: begin
                // action_q is the strobe currently on the port
                state_d = (action_q == ActPull) ? StCapture : StRecv;
            end
            StCapture: begin
                shift_d     = dout_i;
                out_data_d  = dout_i[7:0];
                out_valid_d = 1'b1;
                send_cnt_d  = '0;
                state_d     = StSend;
            end
            StSend: begin
                // out_valid_q is high for the whole of SEND
                if (out_ready_i) begin
                    if (send_cnt_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        state_d     = StRecv;
                    end else begin
                        shift_d    = {8'h00, shift_q[31:8]};
                        out_data_d = shift_q[15:8];
                        send_cnt_d = send_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = StRecv;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StRecv;
            byte_cnt_q  <= '0;
            cmd_act_q   <= '0;
            cmd_midx_q  <= '0;
            cmd_idx_q   <= '0;
            cmd_data_q  <= '0;
            wait_cnt_q  <= '0;
            action_q    <= '0;
            mindex_q    <= '0;
            index_q     <= '0;
            din_q       <= '0;
            shift_q     <= '0;
            send_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_act_q   <= cmd_act_d;
            cmd_midx_q  <= cmd_midx_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_data_q  <= cmd_data_d;
            wait_cnt_q  <= wait_cnt_d;
            action_q    <= action_d;
            mindex_q    <= mindex_d;
            index_q     <= index_d;
            din_q       <= din_d;
            shift_q     <= shift_d;
            send_cnt_q  <= send_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o  = (state_q == StRecv);
    assign busy_o      = (state_q != StRecv);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign action_o    = action_q;
    assign mindex_o    = mindex_q;
    assign index_o     = index_q;
    assign din_o       = din_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pio_cmd_master.sv
// Directed bench for pio_cmd_master. Two instances share all inputs: dut waits forever
// (WAIT_LIMIT=0), dut_to drops commands after 8 WAIT cycles.
module tb_pio_cmd_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic [31:0] dout;
    logic [3:0]  full;
    logic [3:0]  empty;

    logic        in_ready, out_valid, busy, err;
    logic [7:0]  out_data;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic [4:0]  index;
    logic [31:0] din;

    logic        t_in_ready, t_out_valid, t_busy, t_err;
    logic [7:0]  t_out_data;
    logic [3:0]  t_action;
    logic [1:0]  t_mindex;
    logic [4:0]  t_index;
    logic [31:0] t_din;

    int n_cmp = 0;
    int n_err = 0;

    int          bad;
    int          ptr, nstrobe, s0, s1, low;
    logic [4:0]  ix0, ix1;
    logic [1:0]  m1;
    logic [7:0]  exp_b [8];
    logic [7:0]  b2b [12];

    always #5 clk = ~clk;

    pio_cmd_master #(.WAIT_LIMIT(0)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .action_o(action), .mindex_o(mindex), .index_o(index), .din_o(din),
        .dout_i(dout), .full_i(full), .empty_i(empty),
        .busy_o(busy), .err_o(err)
    );

    pio_cmd_master #(.WAIT_LIMIT(8)) dut_to (
        .clk_i(clk), .reset_ni(reset_n),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(t_in_ready),
        .out_valid_o(t_out_valid), .out_data_o(t_out_data), .out_ready_i(out_ready),
        .action_o(t_action), .mindex_o(t_mindex), .index_o(t_index), .din_o(t_din),
        .dout_i(dout), .full_i(full), .empty_i(empty),
        .busy_o(t_busy), .err_o(t_err)
    );

    // PIO read model: dout carries the word only in the cycle after a PULL strobe
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) dout <= 32'h0;
        else          dout <= (action == 4'd3) ? 32'hCAFEF00D : 32'h0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Six consecutive accepted bytes; returns one cycle after the last accept (N+1)
    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        logic [7:0] b [6];
        b = '{b0, b1, b2, b3, b4, b5};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        full      = 4'h0;
        empty     = 4'hF;
        tick();
        tick();

        // Reset values
        check_eq("rst_action", action, 0);
        check_eq("rst_mindex", mindex, 0);
        check_eq("rst_index", index, 0);
        check_eq("rst_din", din, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick();
        check_eq("rst_in_ready", in_ready, 1);

        // INSTR
        send_pkt(8'h01, 8'h07, 8'h34, 8'h12, 8'h00, 8'h00);
        check_eq("instr_n1_action", action, 0);
        check_eq("instr_n1_busy", busy, 1);
        check_eq("instr_n1_in_ready", in_ready, 0);
        tick();
        check_eq("instr_action", action, 1);
        check_eq("instr_index", index, 7);
        check_eq("instr_mindex", mindex, 0);
        check_eq("instr_din", din, 32'h00001234);
        tick();
        check_eq("instr_n3_action", action, 0);
        check_eq("instr_n3_in_ready", in_ready, 1);

        // PUSH blocked by full[2] for 10 cycles
        full = 4'b0100;
        send_pkt(8'h24, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (action != 4'd0 || in_ready != 1'b0) bad++;
            tick();
        end
        check_eq("push_blocked_quiet", bad, 0);
        full = 4'b0000;
        tick();
        check_eq("push_action", action, 4);
        check_eq("push_mindex", mindex, 2);
        check_eq("push_din", din, 32'hDEADBEEF);
        tick();
        check_eq("push_strobe_end", action, 0);

        // PULL on machine 1 with toggling out_ready
        empty = 4'b1101;
        send_pkt(8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        check_eq("pull_action", action, 3);
        check_eq("pull_mindex", mindex, 1);
        tick();
        check_eq("pull_capture_no_valid", out_valid, 0);
        tick();
        exp_b = '{8'h0D, 8'h0D, 8'hF0, 8'hF0, 8'hFE, 8'hFE, 8'hCA, 8'hCA};
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 1);
            check_eq($sformatf("pull_valid%0d", i), out_valid, 1);
            check_eq($sformatf("pull_byte%0d", i), out_data, exp_b[i]);
            tick();
        end
        out_ready = 1'b0;
        check_eq("pull_done_valid", out_valid, 0);
        check_eq("pull_done_busy", busy, 0);
        empty = 4'hF;

        // Back-to-back INSTR packets with in_valid held high
        b2b = '{8'h01, 8'h0A, 8'h11, 8'h00, 8'h00, 8'h00,
                8'h21, 8'h0B, 8'h22, 8'h00, 8'h00, 8'h00};
        ptr = 0; nstrobe = 0; s0 = -1; s1 = -1; low = 0; ix0 = '0; ix1 = '0; m1 = '0;
        for (int c = 0; c < 24; c++) begin
            in_valid = (ptr < 12);
            in_data  = (ptr < 12) ? b2b[ptr] : 8'h00;
            if (action != 4'd0) begin
                if (nstrobe == 0) begin
                    s0 = c; ix0 = index;
                end else if (nstrobe == 1) begin
                    s1 = c; ix1 = index; m1 = mindex;
                end
                nstrobe++;
            end
            if (!in_ready && c < 16) low++;
            if (in_valid && in_ready) ptr++;
            tick();
        end
        in_valid = 1'b0;
        check_eq("b2b_strobes", nstrobe, 2);
        check_eq("b2b_first_cycle", s0, 7);
        check_eq("b2b_spacing", s1 - s0, 8);
        check_eq("b2b_index0", ix0, 5'h0A);
        check_eq("b2b_index1", ix1, 5'h0B);
        check_eq("b2b_mindex1", m1, 2);
        check_eq("b2b_not_ready_cycles", low, 4);

        // Timeout on dut_to: PULL machine 0, empty[0] held
        empty = 4'hF;
        send_pkt(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (t_err || t_action != 4'd0 || !t_busy) bad++;
            tick();
        end
        check_eq("to_wait_quiet", bad, 0);
        check_eq("to_err_pulse", t_err, 1);
        check_eq("to_in_ready", t_in_ready, 1);
        check_eq("to_no_output", t_out_valid, 0);
        tick();
        check_eq("to_err_single", t_err, 0);
        check_eq("nolimit_still_waiting", busy, 1);
        check_eq("nolimit_no_err", err, 0);
        send_pkt(8'h01, 8'h07, 8'h34, 8'h12, 8'h00, 8'h00);
        tick();
        check_eq("to_next_action", t_action, 1);
        check_eq("to_next_index", t_index, 7);
        check_eq("to_next_din", t_din, 32'h00001234);
        tick();
        check_eq("to_next_strobe_end", t_action, 0);

        // Reset after 3 bytes of a packet
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 8'h24 : ((i == 1) ? 8'h05 : 8'hFF);
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_eq("midrst_action", t_action, 0);
        check_eq("midrst_index", t_index, 0);
        check_eq("midrst_din", t_din, 0);
        check_eq("midrst_out_data", t_out_data, 0);
        check_eq("midrst_mindex", t_mindex, 0);
        check_eq("midrst_err", t_err, 0);
        check_eq("midrst_out_valid", t_out_valid, 0);
        check_eq("midrst_dut_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        send_pkt(8'h01, 8'h1F, 8'h78, 8'h56, 8'h34, 8'h12);
        tick();
        check_eq("fresh_action", t_action, 1);
        check_eq("fresh_index", t_index, 5'h1F);
        check_eq("fresh_din", t_din, 32'h12345678);
        check_eq("fresh_mindex", t_mindex, 0);
        check_eq("fresh_dut_action", action, 1);
        check_eq("fresh_dut_din", din, 32'h12345678);
        tick();
        check_eq("fresh_strobe_end", t_action, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
